// File: rtl/voice_mixer.sv
// voice_mixer: scans the oscillator bank one voice per cycle, sums the enabled
// voices, scales by 2^-(FRAC+MIX_SHIFT) with floor rounding, saturates to WIDTH
// bits and presents the result with a one-cycle valid strobe.
// Optional feature macro: VOICE_MIXER_DC_BLOCK_EN inserts a one-pole DC blocker
// stage (extra DCB state, one more cycle of latency).

`ifndef FIXED_POINT
`define FIXED_POINT 8
`endif
`ifndef N_OSCILLATORS
`define N_OSCILLATORS 4
`endif

module voice_mixer #(
    parameter int WIDTH     = 24,
    parameter int FRAC      = `FIXED_POINT,
    parameter int N_VOICES  = `N_OSCILLATORS,
    parameter int MIX_SHIFT = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 sample_tick,
    output logic [$clog2(N_VOICES+1)-1:0]        index,
    input  logic signed [WIDTH+FRAC-1:0]         osc_out,
    input  logic                                 osc_enabled,
    output logic signed [WIDTH-1:0]              sample_out,
    output logic                                 sample_valid,
    output logic [$clog2(N_VOICES+1)-1:0]        active_voices,
    output logic                                 busy,
    output logic                                 overrun
);

    localparam int IW    = $clog2(N_VOICES+1);
    localparam int ACC_W = WIDTH + FRAC + $clog2(N_VOICES) + 1;

    // Clamp limits expressed at accumulator width so the compare is exact.
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] OUT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] OUT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        SCALE,
`ifdef VOICE_MIXER_DC_BLOCK_EN
        DCB,
`endif
        OUT
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic signed [ACC_W-1:0] acc;
    logic [IW-1:0]           voice_cnt;
    logic signed [ACC_W-1:0] osc_ext;
    logic signed [ACC_W-1:0] scaled;
    logic signed [WIDTH-1:0] sat_val;
    logic                    last_voice;

`ifdef VOICE_MIXER_DC_BLOCK_EN
    logic signed [WIDTH-1:0] x_cur;
    logic signed [WIDTH-1:0] x_prev;
    logic signed [WIDTH-1:0] y_prev;
    logic signed [WIDTH+1:0] dcb_sum;
    logic signed [WIDTH-1:0] dcb_sat;

    // One-pole high-pass: y = x - x_prev + y_prev - y_prev/1024, clamped to WIDTH.
    always_comb begin
        dcb_sum = {{2{x_cur[WIDTH-1]}}, x_cur} - {{2{x_prev[WIDTH-1]}}, x_prev}
                + {{2{y_prev[WIDTH-1]}}, y_prev}
                - ({{2{y_prev[WIDTH-1]}}, y_prev} >>> 10);
        dcb_sat = dcb_sum[WIDTH-1:0];
        if (dcb_sum > {{2{OUT_MAX[WIDTH-1]}}, OUT_MAX}) begin
            dcb_sat = OUT_MAX;
        end else if (dcb_sum < {{2{OUT_MIN[WIDTH-1]}}, OUT_MIN}) begin
            dcb_sat = OUT_MIN;
        end
    end
`endif

    // Sign-extend the voice sample, floor-scale the sum and clamp it to WIDTH bits.
    always_comb begin
        osc_ext    = {{(ACC_W-WIDTH-FRAC){osc_out[WIDTH+FRAC-1]}}, osc_out};
        last_voice = (index == IW'(N_VOICES-1));
        scaled     = acc >>> (FRAC + MIX_SHIFT);
        sat_val    = scaled[WIDTH-1:0];
        if (scaled > SAT_MAX) begin
            sat_val = OUT_MAX;
        end else if (scaled < SAT_MIN) begin
            sat_val = OUT_MIN;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: one frame is IDLE -> SCAN (N cycles) -> SCALE [-> DCB] -> OUT.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (sample_tick) state_next = SCAN;
            SCAN:  if (last_voice) state_next = SCALE;
`ifdef VOICE_MIXER_DC_BLOCK_EN
            SCALE: state_next = DCB;
            DCB:   state_next = OUT;
`else
            SCALE: state_next = OUT;
`endif
            OUT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: voice scan, accumulation, result/strobe registers and the sticky overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            index         <= IW'(N_VOICES);
            acc           <= '0;
            voice_cnt     <= '0;
            sample_out    <= '0;
            sample_valid  <= 1'b0;
            active_voices <= '0;
            busy          <= 1'b0;
            overrun       <= 1'b0;
`ifdef VOICE_MIXER_DC_BLOCK_EN
            x_cur         <= '0;
            x_prev        <= '0;
            y_prev        <= '0;
`endif
        end else begin
            sample_valid <= 1'b0;
            if (sample_tick && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (sample_tick) begin
                        acc       <= '0;
                        voice_cnt <= '0;
                        index     <= '0;
                        busy      <= 1'b1;
                    end
                end
                SCAN: begin
                    if (osc_enabled) begin
                        acc       <= acc + osc_ext;
                        voice_cnt <= voice_cnt + IW'(1);
                    end
                    if (last_voice) begin
                        index <= IW'(N_VOICES);
                    end else begin
                        index <= index + IW'(1);
                    end
                end
                SCALE: begin
`ifdef VOICE_MIXER_DC_BLOCK_EN
                    x_cur <= sat_val;
`else
                    sample_out    <= sat_val;
                    sample_valid  <= 1'b1;
                    active_voices <= voice_cnt;
`endif
                end
`ifdef VOICE_MIXER_DC_BLOCK_EN
                DCB: begin
                    sample_out    <= dcb_sat;
                    sample_valid  <= 1'b1;
                    active_voices <= voice_cnt;
                    x_prev        <= x_cur;
                    y_prev        <= dcb_sat;
                end
`endif
                OUT: begin
                    busy <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_voice_mixer.sv
// tb_voice_mixer: table-driven check of voice_mixer (default build) using two
// instances, MIX_SHIFT=2 and MIX_SHIFT=0, fed from the same per-voice table,
// plus hand-written overrun, tick-in-OUT and mid-frame reset sequences.

module tb_voice_mixer;

    localparam int WIDTH = 24;
    localparam int FRAC  = 8;
    localparam int NV    = 4;
    localparam int IW    = 3;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    sample_tick;
    logic signed [31:0]      osc_out;
    logic                    osc_enabled;
    logic [IW-1:0]           index_a, index_b;
    logic signed [WIDTH-1:0] sample_out_a, sample_out_b;
    logic                    sample_valid_a, sample_valid_b;
    logic [IW-1:0]           active_a, active_b;
    logic                    busy_a, busy_b;
    logic                    overrun_a, overrun_b;

    logic signed [31:0]      voice_val [NV];
    logic [NV-1:0]           voice_en;

    int checks = 0;
    int passes = 0;

    typedef struct {
        string              name;
        logic signed [31:0] v0, v1, v2, v3;
        logic [NV-1:0]      en;
        int                 exp2;
        int                 exp0;
        int                 act;
    } vec_t;

    vec_t vecs [7];

    voice_mixer #(.WIDTH(WIDTH), .FRAC(FRAC), .N_VOICES(NV), .MIX_SHIFT(2)) dut_a (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .index(index_a),
        .osc_out(osc_out), .osc_enabled(osc_enabled), .sample_out(sample_out_a),
        .sample_valid(sample_valid_a), .active_voices(active_a), .busy(busy_a),
        .overrun(overrun_a)
    );

    voice_mixer #(.WIDTH(WIDTH), .FRAC(FRAC), .N_VOICES(NV), .MIX_SHIFT(0)) dut_b (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .index(index_b),
        .osc_out(osc_out), .osc_enabled(osc_enabled), .sample_out(sample_out_b),
        .sample_valid(sample_valid_b), .active_voices(active_b), .busy(busy_b),
        .overrun(overrun_b)
    );

    always #5 clk = ~clk;

    // Model of the oscillator bank: combinational lookup on the selected voice.
    always_comb begin
        osc_out     = '0;
        osc_enabled = 1'b0;
        if (index_a < IW'(NV)) begin
            osc_out     = voice_val[index_a[1:0]];
            osc_enabled = voice_en[index_a[1:0]];
        end
    end

    function automatic vec_t make_vec(input string name, input int v0, input int v1,
                                      input int v2, input int v3, input logic [NV-1:0] en,
                                      input int exp2, input int exp0, input int act);
        vec_t r;
        r.name = name;
        r.v0 = v0; r.v1 = v1; r.v2 = v2; r.v3 = v3;
        r.en = en; r.exp2 = exp2; r.exp0 = exp0; r.act = act;
        return r;
    endfunction

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic doReset();
        rst         = 1'b1;
        sample_tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Runs one frame; a second tick is raised during cycle T+extra_tick (0 = none).
    task automatic applyStimulus(input vec_t v, input int extra_tick);
        int  cyc;
        int  exp_idx;
        bit  got;
        bit  seq_ok;
        bit  busy_ok;
        voice_val[0] = v.v0; voice_val[1] = v.v1;
        voice_val[2] = v.v2; voice_val[3] = v.v3;
        voice_en     = v.en;
        sample_tick  = 1'b1;
        cyc     = 0;
        got     = 1'b0;
        seq_ok  = 1'b1;
        busy_ok = 1'b1;
        while (!got && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            sample_tick = (cyc == extra_tick);
            exp_idx = (cyc <= NV + 1) ? cyc - 1 : NV;
            if (index_a != IW'(exp_idx)) seq_ok = 1'b0;
            if (!busy_a) busy_ok = 1'b0;
            if (sample_valid_a) got = 1'b1;
        end
        checkOutput({v.name, "_latency"}, got ? cyc : -1, NV + 2);
        checkOutput({v.name, "_index_seq"}, seq_ok, 1);
        checkOutput({v.name, "_busy"}, busy_ok, 1);
        checkOutput({v.name, "_out_shift2"}, sample_out_a, v.exp2);
        checkOutput({v.name, "_out_shift0"}, sample_out_b, v.exp0);
        checkOutput({v.name, "_active"}, active_a, v.act);
        checkOutput({v.name, "_valid_b"}, sample_valid_b, 1);
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
        checkOutput({v.name, "_valid_pulse"}, sample_valid_a, 0);
        checkOutput({v.name, "_hold"}, sample_out_a, v.exp2);
    endtask

    initial begin
        int  cyc;
        bit  saw_valid;

        vecs[0] = make_vec("all_on",  256000, 256000, 256000, 256000, 4'b1111, 1000, 4000, 4);
        vecs[1] = make_vec("v1_off",  256000, 256000, 256000, 256000, 4'b1101, 750, 3000, 3);
        vecs[2] = make_vec("floor",   -256, 0, 0, 0, 4'b1111, -1, -1, 4);
        vecs[3] = make_vec("sat_pos", 32'sh7FFFFF00, 32'sh7FFFFF00, 32'sh7FFFFF00, 32'sh7FFFFF00,
                           4'b1111, 8388607, 8388607, 4);
        vecs[4] = make_vec("sat_neg", 32'sh80000000, 32'sh80000000, 32'sh80000000, 32'sh80000000,
                           4'b1111, -8388608, -8388608, 4);
        vecs[5] = make_vec("all_off", 12345, -777, 99999, 5, 4'b0000, 0, 0, 0);
        vecs[6] = make_vec("mixed",   25600, -51200, 102400, 999, 4'b0111, 75, 300, 3);

        voice_en = '0;
        for (int i = 0; i < NV; i++) voice_val[i] = '0;

        doReset();
        checkOutput("rst_index", index_a, NV);
        checkOutput("rst_sample_out", sample_out_a, 0);
        checkOutput("rst_valid", sample_valid_a, 0);
        checkOutput("rst_active", active_a, 0);
        checkOutput("rst_busy", busy_a, 0);
        checkOutput("rst_overrun", overrun_a, 0);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i], 0);
        end
        checkOutput("no_overrun_yet", overrun_a, 0);

        // Second tick during T+3 is ignored but flagged.
        applyStimulus(vecs[1], 3);
        checkOutput("overrun_set", overrun_a, 1);
        applyStimulus(vecs[0], 0);
        checkOutput("overrun_sticky", overrun_a, 1);

        // Tick coinciding with OUT is an overrun; a frame can start right after.
        doReset();
        checkOutput("overrun_cleared", overrun_a, 0);
        applyStimulus(vecs[0], NV + 2);
        checkOutput("out_tick_overrun", overrun_a, 1);
        checkOutput("out_tick_busy", busy_a, 0);
        checkOutput("out_tick_index", index_a, NV);
        applyStimulus(vecs[6], 0);

        // Reset during T+2 aborts the frame with no strobe.
        doReset();
        voice_en    = 4'b1111;
        sample_tick = 1'b1;
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort_index", index_a, NV);
        checkOutput("abort_busy", busy_a, 0);
        saw_valid = 1'b0;
        for (cyc = 0; cyc < 10; cyc++) begin
            if (sample_valid_a) saw_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        checkOutput("abort_no_valid", saw_valid, 0);
        checkOutput("abort_active", active_a, 0);
        checkOutput("abort_sample_out", sample_out_a, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
